// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer.
// These cover the fetch FSM state encoding and the widths of the {PC, instruction} entry.
package inst_fetch_buffer_pkg;

  localparam int IFB_PCW = 30;
  localparam int IFB_IW  = 32;
  localparam int IFB_EW  = IFB_PCW + IFB_IW;

  typedef enum logic [1:0] {
    IFB_IDLE = 2'd0,
    IFB_REQ  = 2'd1,
    IFB_GAP  = 2'd2
  } ifb_state_e;

  // Word addresses wrap modulo 2^30.
  function automatic logic [IFB_PCW-1:0] ifb_next_pc(input logic [IFB_PCW-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_fifo.sv
// Synchronous FIFO for {PC, instruction} entries, with a flush that empties it in one cycle.
// The pointers carry one extra wrap bit, so the FIFO can tell full from empty.
module inst_fetch_buffer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 62
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is data-only, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Sequential instruction prefetcher: Read/Ready fetch FSM, PC register and FIFO to decode.
// Define IFB_BYPASS_EN to let a word fetched into an empty FIFO reach Fetch_* in its Ready cycle.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int                 DEPTH       = 4,
  parameter logic [IFB_PCW-1:0] RESET_WADDR = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [IFB_PCW-1:0] InstMem_Address,
  output logic               InstMem_Read,
  input  logic               InstMem_Ready,
  input  logic [IFB_IW-1:0]  InstMem_In,
  output logic               Fetch_Valid,
  output logic [IFB_IW-1:0]  Fetch_Inst,
  output logic [IFB_PCW-1:0] Fetch_PC,
  input  logic               Fetch_Accept,
  input  logic               Redirect,
  input  logic [IFB_PCW-1:0] Redirect_Address
);

  ifb_state_e         state_q, state_d;
  logic [IFB_PCW-1:0] pc_q, pc_d;
  logic               read_q, read_d;
  logic               push_req, fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [IFB_EW-1:0]  fifo_head;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push_req = 1'b0;
    case (state_q)
      IFB_IDLE: if (!fifo_full) state_d = IFB_REQ;
      IFB_REQ: begin
        if (InstMem_Ready) begin
          push_req = 1'b1;
          pc_d     = ifb_next_pc(pc_q);
          state_d  = IFB_GAP;
        end
      end
      // The ack is registered in IM, so Ready may still be high here and is ignored.
      IFB_GAP:  state_d = fifo_full ? IFB_IDLE : IFB_REQ;
      default:  state_d = IFB_IDLE;
    endcase
    // A redirect drops any word arriving this cycle and restarts through GAP.
    if (Redirect) begin
      state_d  = IFB_GAP;
      pc_d     = Redirect_Address;
      push_req = 1'b0;
    end
    read_d = (state_d == IFB_REQ);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IFB_IDLE;
      pc_q    <= RESET_WADDR;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      read_q  <= read_d;
    end
  end

  assign InstMem_Read    = read_q;
  assign InstMem_Address = pc_q;

`ifdef IFB_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass      = fifo_empty && push_req;
    Fetch_Valid = !fifo_empty || bypass;
    Fetch_Inst  = bypass ? InstMem_In : fifo_head[IFB_IW-1:0];
    Fetch_PC    = bypass ? pc_q : fifo_head[IFB_EW-1:IFB_IW];
    fifo_push   = push_req && !(bypass && Fetch_Accept);
    fifo_pop    = !fifo_empty && Fetch_Accept && !Redirect;
  end
`else
  always_comb begin
    Fetch_Valid = !fifo_empty;
    Fetch_Inst  = fifo_head[IFB_IW-1:0];
    Fetch_PC    = fifo_head[IFB_EW-1:IFB_IW];
    fifo_push   = push_req;
    fifo_pop    = !fifo_empty && Fetch_Accept && !Redirect;
  end
`endif

  inst_fetch_buffer_fifo #(
    .DEPTH (DEPTH),
    .W     (IFB_EW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (Redirect),
    .din   ({pc_q, InstMem_In}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule
